// File: rtl/cnt_seq_checker_pkg.sv
// Shared types and constants for the wrapping-counter sequence checker.
package cnt_seq_checker_pkg;

    // Checker phases: no reference yet, hunting for a run, locked, slipping
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEEK   = 2'd1,
        LOCKED = 2'd2,
        SLIP   = 2'd3
    } state_e;

    // Prefix used by the optional diagnostic messages
    localparam MSG_PREFIX = "CHK";

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/cnt_seq_checker_if.sv
// Observed count bus plus checker status outputs.
// Handshake: cnt_vld_i alone qualifies cnt_i in the cycle it is high; there is
// no ready, the checker accepts every valid sample. clr_i is an unqualified
// level sampled on each rising edge. dbg_state_o exposes the checker FSM.
interface cnt_seq_checker_if #(
    parameter int CNT_W = 4,
    parameter int ERR_W = 8
);
    logic [CNT_W-1:0] cnt_i;
    logic             cnt_vld_i;
    logic             clr_i;
    logic             locked_o;
    logic             err_pulse_o;
    logic [ERR_W-1:0] err_cnt_o;
    logic [CNT_W-1:0] exp_o;
    logic [1:0]       dbg_state_o;

    modport master (
        output cnt_i, cnt_vld_i, clr_i,
        input  locked_o, err_pulse_o, err_cnt_o, exp_o, dbg_state_o
    );

    modport slave (
        input  cnt_i, cnt_vld_i, clr_i,
        output locked_o, err_pulse_o, err_cnt_o, exp_o, dbg_state_o
    );
endinterface

// File: rtl/cnt_seq_checker_sat_cnt.sv
// Saturating error counter; a clear coincident with an increment yields 1.
module sat_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc_i,
    input  logic         clr_i,
    output logic [W-1:0] cnt_o
);
    localparam logic [W-1:0] MAX_V = {W{1'b1}};

    logic [W-1:0] cnt_q, cnt_d;

    // Next count: clear wins but keeps a same-cycle increment, else saturate
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = inc_i ? W'(1) : '0;
        end else if (inc_i && (cnt_q != MAX_V)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // Count register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;
endmodule

// File: rtl/cnt_seq_checker.sv
// Sequence checker for a free-running wrapping up-counter.
// Optional macro CNT_SEQ_CHECKER_DISPLAY_EN prints mismatch and lock messages.
module cnt_seq_checker
    import cnt_seq_checker_pkg::*;
#(
    parameter int CNT_W  = 4,
    parameter int LOCK_N = 3,
    parameter int LOSS_N = 2,
    parameter int ERR_W  = 8
) (
    input  logic            clk,
    input  logic            rst,
    cnt_seq_checker_if.slave bus
);
    localparam int CW = $clog2(max2(LOCK_N, LOSS_N) + 1);
    localparam logic [CW-1:0] LOCK_V = CW'(LOCK_N);
    localparam logic [CW-1:0] LOSS_V = CW'(LOSS_N);

    localparam logic [1:0] S_IDLE   = 2'(IDLE);
    localparam logic [1:0] S_SEEK   = 2'(SEEK);
    localparam logic [1:0] S_LOCKED = 2'(LOCKED);
    localparam logic [1:0] S_SLIP   = 2'(SLIP);

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    match_cnt_q, match_cnt_d;
    logic [CW-1:0]    miss_cnt_q, miss_cnt_d;
    logic [CNT_W-1:0] exp_q, exp_d;
    logic             locked_q, locked_d;
    logic             err_pulse_q, err_pulse_d;
    logic             err_inc;
    logic             match;

    // FSM next state; every valid sample re-phases the reference to cnt_i
    always_comb begin
        state_d     = state_q;
        match_cnt_d = match_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        exp_d       = exp_q;
        err_inc     = 1'b0;
        match       = (bus.cnt_i == exp_q);
        if (bus.cnt_vld_i) begin
            exp_d = bus.cnt_i + CNT_W'(1);
            case (state_q)
                S_IDLE: begin
                    state_d     = S_SEEK;
                    match_cnt_d = '0;
                end
                S_SEEK: begin
                    if (match) begin
                        match_cnt_d = match_cnt_q + CW'(1);
                        if (match_cnt_d == LOCK_V) state_d = S_LOCKED;
                    end else begin
                        match_cnt_d = '0;
                    end
                end
                S_LOCKED: begin
                    if (!match) begin
                        err_inc = 1'b1;
                        if (LOSS_N == 1) begin
                            state_d     = S_SEEK;
                            match_cnt_d = '0;
                        end else begin
                            state_d    = S_SLIP;
                            miss_cnt_d = CW'(1);
                        end
                    end
                end
                S_SLIP: begin
                    if (match) begin
                        state_d    = S_LOCKED;
                        miss_cnt_d = '0;
                    end else begin
                        err_inc    = 1'b1;
                        miss_cnt_d = miss_cnt_q + CW'(1);
                        if (miss_cnt_d == LOSS_V) begin
                            state_d     = S_SEEK;
                            match_cnt_d = '0;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
        locked_d    = (state_d == S_LOCKED) || (state_d == S_SLIP);
        err_pulse_d = err_inc;
    end

    // State and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            match_cnt_q <= '0;
            miss_cnt_q  <= '0;
            exp_q       <= '0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            match_cnt_q <= match_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
            exp_q       <= exp_d;
            locked_q    <= locked_d;
            err_pulse_q <= err_pulse_d;
        end
    end

    sat_cnt #(.W(ERR_W)) u_err_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc_i (err_inc),
        .clr_i (bus.clr_i),
        .cnt_o (bus.err_cnt_o)
    );

    assign bus.locked_o    = locked_q;
    assign bus.err_pulse_o = err_pulse_q;
    assign bus.exp_o       = exp_q;
    assign bus.dbg_state_o = state_q;

`ifdef CNT_SEQ_CHECKER_DISPLAY_EN
    // Diagnostic messages for counted errors and lock transitions
    always @(posedge clk) begin
        if (!rst && err_inc)
            $display("@%0t %s mismatch got=%0d exp=%0d", $time, MSG_PREFIX, bus.cnt_i, exp_q);
        if (!rst && (locked_d != locked_q))
            $display("@%0t %s lock=%0d", $time, MSG_PREFIX, locked_d);
    end
`else
    // Messages disabled: behaviour is otherwise identical
`endif

endmodule

// File: tb/tb_cnt_seq_checker.sv
// Scoreboard bench for cnt_seq_checker: default instance plus an ERR_W=2 copy.
module tb_cnt_seq_checker;
    localparam int CNT_W  = 4;
    localparam int LOCK_N = 3;
    localparam int LOSS_N = 2;
    localparam int ERR_W  = 8;
    localparam int ERR_W2 = 2;
    localparam int EW     = 1 + 1 + ERR_W + ERR_W2 + CNT_W;
    localparam int MOD    = 1 << CNT_W;
    localparam int MAX8   = (1 << ERR_W) - 1;
    localparam int MAX2   = (1 << ERR_W2) - 1;

    // clock / reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cnt_seq_checker_if #(.CNT_W(CNT_W), .ERR_W(ERR_W))  bus ();
    cnt_seq_checker_if #(.CNT_W(CNT_W), .ERR_W(ERR_W2)) bus2 ();

    assign bus2.cnt_i     = bus.cnt_i;
    assign bus2.cnt_vld_i = bus.cnt_vld_i;
    assign bus2.clr_i     = bus.clr_i;

    cnt_seq_checker #(.CNT_W(CNT_W), .LOCK_N(LOCK_N), .LOSS_N(LOSS_N), .ERR_W(ERR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    cnt_seq_checker #(.CNT_W(CNT_W), .LOCK_N(LOCK_N), .LOSS_N(LOSS_N), .ERR_W(ERR_W2)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    // scoreboard
    logic [EW-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    // reference model: run-length view of the sample stream
    bit m_have_ref, m_locked;
    int m_run, m_miss, m_exp, m_err8, m_err2;

    function void model_reset();
        m_have_ref = 0; m_locked = 0;
        m_run = 0; m_miss = 0; m_exp = 0; m_err8 = 0; m_err2 = 0;
    endfunction

    function logic [EW-1:0] model_step(bit vld, int cnt, bit clr);
        bit err;
        err = 0;
        if (vld) begin
            if (!m_have_ref) begin
                m_have_ref = 1;
                m_run = 0;
            end else if (!m_locked) begin
                m_run = (cnt == m_exp) ? m_run + 1 : 0;
                if (m_run >= LOCK_N) begin
                    m_locked = 1;
                    m_miss = 0;
                end
            end else if (cnt == m_exp) begin
                m_miss = 0;
            end else begin
                err = 1;
                m_miss++;
                if (m_miss >= LOSS_N) begin
                    m_locked = 0;
                    m_run = 0;
                end
            end
            m_exp = (cnt + 1) % MOD;
        end
        if (clr) begin
            m_err8 = err ? 1 : 0;
            m_err2 = err ? 1 : 0;
        end else if (err) begin
            if (m_err8 < MAX8) m_err8++;
            if (m_err2 < MAX2) m_err2++;
        end
        return {m_locked, err, ERR_W'(m_err8), ERR_W2'(m_err2), CNT_W'(m_exp)};
    endfunction

    // driver: apply one cycle of input, push the expected post-edge outputs
    task drive(input bit vld, input int cnt, input bit clr);
        logic [EW-1:0] e;
        bus.cnt_vld_i = vld;
        bus.cnt_i     = CNT_W'(cnt);
        bus.clr_i     = clr;
        e = model_step(vld, cnt, clr);
        @(posedge clk);
        exp_q.push_back(e);
        #1;
    endtask

    task check_reset(input string name);
        checks++;
        if (bus.locked_o !== 1'b0 || bus.err_pulse_o !== 1'b0 || bus.err_cnt_o !== '0 ||
            bus.exp_o !== '0 || bus2.err_cnt_o !== '0 || bus2.locked_o !== 1'b0) begin
            errors++;
            $display("FAIL %s: got lock=%0d pulse=%0d err=%0d err2=%0d exp=%0d, want all 0",
                     name, bus.locked_o, bus.err_pulse_o, bus.err_cnt_o, bus2.err_cnt_o, bus.exp_o);
        end
    endtask

    // monitor: compare every presented output cycle against the queue head
    logic [EW-1:0] mon_e;
    always @(negedge clk) begin
        if (!rst && exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            checks++;
            if (bus.locked_o    !== mon_e[EW-1] || bus2.locked_o    !== mon_e[EW-1] ||
                bus.err_pulse_o !== mon_e[EW-2] || bus2.err_pulse_o !== mon_e[EW-2] ||
                bus.err_cnt_o   !== mon_e[CNT_W+ERR_W2 +: ERR_W] ||
                bus2.err_cnt_o  !== mon_e[CNT_W +: ERR_W2] ||
                bus.exp_o       !== mon_e[CNT_W-1:0] || bus2.exp_o !== mon_e[CNT_W-1:0]) begin
                errors++;
                $display("FAIL outputs @%0t: got lock=%0d/%0d pulse=%0d/%0d err=%0d err2=%0d exp=%0d/%0d, want lock=%0d pulse=%0d err=%0d err2=%0d exp=%0d",
                         $time, bus.locked_o, bus2.locked_o, bus.err_pulse_o, bus2.err_pulse_o,
                         bus.err_cnt_o, bus2.err_cnt_o, bus.exp_o, bus2.exp_o,
                         mon_e[EW-1], mon_e[EW-2], mon_e[CNT_W+ERR_W2 +: ERR_W],
                         mon_e[CNT_W +: ERR_W2], mon_e[CNT_W-1:0]);
            end
        end
    end

    // watchdog
    initial begin
        #300000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // stimulus
    initial begin
        int r, c;
        bus.cnt_vld_i = 1'b0;
        bus.cnt_i     = '0;
        bus.clr_i     = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset("reset_init");
        rst = 1'b0;

        // lock on 0,1,2,3
        for (int i = 0; i < 4; i++) drive(1, i, 0);
        // run through the wrap 15 -> 0 -> 1
        for (int i = 4; i < 18; i++) drive(1, i % MOD, 0);
        // locked at 5, then 7 (skip), two idle cycles, 8 (back in step)
        for (int i = 2; i < 6; i++) drive(1, i, 0);
        drive(1, 7, 0);
        drive(0, 3, 0);
        drive(0, 12, 0);
        drive(1, 8, 0);
        // locked at 3, then 9,2 drop lock, then 3,4,5 relock
        for (int i = 9; i < 20; i++) drive(1, i % MOD, 0);
        drive(1, 9, 0);
        drive(1, 2, 0);
        for (int i = 3; i < 6; i++) drive(1, i, 0);
        // more errors to saturate the 2-bit counter
        drive(1, 7, 0);
        drive(1, 8, 0);
        drive(1, 10, 0);
        // clear together with a mismatch, then a clear alone
        drive(1, 0, 1);
        drive(0, 5, 1);
        // relock and build up four errors
        for (int i = 1; i < 4; i++) drive(1, i, 0);
        drive(1, 5, 0);
        drive(1, 6, 0);
        drive(1, 8, 0);
        drive(1, 9, 0);
        drive(1, 11, 0);
        drive(1, 12, 0);
        drive(1, 14, 0);
        drive(1, 15, 0);

        // asynchronous reset between edges
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_reset("reset_async");
        exp_q.delete();
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(1, 10, 0);
        drive(0, 0, 0);
        drive(0, 0, 0);

        // randomized traffic, mostly in sequence with occasional skips
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 15);
            c = (r < 12) ? m_exp : $urandom_range(0, MOD - 1);
            drive($urandom_range(0, 3) != 0, c, $urandom_range(0, 63) == 0);
        end

        drive(0, 0, 0);
        drive(0, 0, 0);
        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending entries, want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
